// File: rtl/mem_refill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_refill_pkg
//  Purpose  : Shared definitions for the memory refill/write controller:
//             FSM state encoding, per-cache block geometry and the
//             port-select type used for grants and the fairness bit.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_refill_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Block geometry: words per block and byte-offset bits within a block
  localparam int IC_WORDS    = 4;
  localparam int DC_WORDS    = 2;
  localparam int IC_OFF_BITS = 4;
  localparam int DC_OFF_BITS = 3;

  // Requesting port select
  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } port_t;

endpackage : mem_refill_pkg
`default_nettype wire

// File: rtl/refill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : refill_arbiter
//  Purpose  : Combinational two-requester arbiter. A lone requester is always
//             granted; when both request, dCache wins unless it was the last
//             port served, in which case iCache wins.
//  Ports    : ic_req, dc_req  - pending requests
//             last_grant      - port served by the previous transaction
//             grant_ic/dc     - one-hot (or zero) grant
//  Revision : 1.0 - initial release
// ============================================================================
module refill_arbiter
  import mem_refill_pkg::*;
(
  input  logic  ic_req,
  input  logic  dc_req,
  input  port_t last_grant,
  output logic  grant_ic,
  output logic  grant_dc
);

  always_comb begin
    grant_dc = dc_req & (~ic_req | (last_grant == IC));
    grant_ic = ic_req & (~dc_req | (last_grant == DC));
  end

endmodule : refill_arbiter
`default_nettype wire

// File: rtl/mem_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_refill_ctrl
//  Purpose  : Refill/write controller below the iCache and dCache. Arbitrates
//             one transaction at a time, waits MEM_LATENCY cycles, then
//             streams one 32-bit word per cycle to/from main memory and
//             pulses the granted cache's ready for one cycle.
//  Ports    : CLK, reset              - clock, synchronous active-high reset
//             ic_req/ic_addr          - iCache 128-bit block refill request
//             ic_data/ic_ready        - assembled iCache block + done pulse
//             dc_req/dc_wen/dc_addr/dc_wdata - dCache refill or 64-bit write
//             dc_data/dc_ready        - assembled dCache block + done pulse
//             mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata - memory word port
//  Revision : 1.0 - initial release
// ============================================================================
module mem_refill_ctrl
  import mem_refill_pkg::*;
#(
  parameter int MEM_LATENCY = 20,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [127:0]      ic_data,
  output logic              ic_ready,
  input  logic              dc_req,
  input  logic              dc_wen,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [63:0]       dc_wdata,
  output logic [63:0]       dc_data,
  output logic              dc_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0]        c_lat_m1  = 8'(MEM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] c_ic_mask = ~ADDR_W'((1 << IC_OFF_BITS) - 1);
  localparam logic [ADDR_W-1:0] c_dc_mask = ~ADDR_W'((1 << DC_OFF_BITS) - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  port_t             r_port;
  port_t             r_last_grant;
  logic              r_wen;
  logic [ADDR_W-1:0] r_base;
  logic [63:0]       r_wdata;
  logic [7:0]        r_cnt;
  logic [1:0]        r_word;
  logic [1:0]        w_last_word;
  logic [127:0]      r_ic_data;
  logic [63:0]       r_dc_data;
  logic              w_grant_ic;
  logic              w_grant_dc;
  logic              w_accept;

  refill_arbiter u_arb (
    .ic_req     (ic_req),
    .dc_req     (dc_req),
    .last_grant (r_last_grant),
    .grant_ic   (w_grant_ic),
    .grant_dc   (w_grant_dc)
  );

  assign w_accept    = (r_state == ST_IDLE) & (w_grant_ic | w_grant_dc);
  assign w_last_word = (r_port == IC) ? 2'(IC_WORDS - 1) : 2'(DC_WORDS - 1);
  assign ic_data     = r_ic_data;
  assign dc_data     = r_dc_data;

  // State register
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)              w_next_state = ST_WAIT;
      ST_WAIT:  if (r_cnt == 8'd0)         w_next_state = ST_BURST;
      ST_BURST: if (r_word == w_last_word) w_next_state = ST_DONE;
      ST_DONE:                             w_next_state = ST_IDLE;
      default:                             w_next_state = ST_IDLE;
    endcase
  end

  // Transaction context, latency counter, word index and data assembly
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_port       <= IC;
      r_last_grant <= IC;
      r_wen        <= 1'b0;
      r_base       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_ic_data    <= '0;
      r_dc_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // Everything the transaction needs is frozen here so later
            // changes on the request inputs cannot disturb it.
            r_port  <= w_grant_dc ? DC : IC;
            r_wen   <= w_grant_dc & dc_wen;
            r_base  <= w_grant_dc ? (dc_addr & c_dc_mask) : (ic_addr & c_ic_mask);
            r_wdata <= dc_wdata;
            r_cnt   <= c_lat_m1;
            r_word  <= '0;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        end
        ST_BURST: begin
          r_word <= r_word + 2'd1;
          if (!r_wen) begin
            // Word 0 lands in the most significant slot: slot base = ~k * 32
            if (r_port == IC) r_ic_data[{~r_word, 5'b0} +: 32]    <= mem_rdata;
            else              r_dc_data[{~r_word[0], 5'b0} +: 32] <= mem_rdata;
          end
        end
        ST_DONE: begin
          r_last_grant <= r_port;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state only
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ic_ready  = 1'b0;
    dc_ready  = 1'b0;
    case (r_state)
      ST_BURST: begin
        mem_addr = r_base | ADDR_W'({r_word, 2'b00});
        if (r_wen) begin
          mem_wr    = 1'b1;
          mem_wdata = r_word[0] ? r_wdata[31:0] : r_wdata[63:32];
        end else begin
          mem_rd = 1'b1;
        end
      end
      ST_DONE: begin
        ic_ready = (r_port == IC);
        dc_ready = (r_port == DC);
      end
      default: ;
    endcase
  end

endmodule : mem_refill_ctrl
`default_nettype wire
